servo_ramp_ctrl: RTL and testbench

Multi-channel motion controller for the arm's servo PWM generators. It accepts per-joint target positions over a valid/ready command port. Once per 20 ms servo frame it moves each channel's current position toward its target by at most a fixed step, which limits joint slew rate. The flattened position bus drives the 8-bit `value` inputs of one PWM servo instance per joint.

---
 rtl/servo_pkg.sv | 7 +
 rtl/frame_timer.sv | 23 ++
 rtl/servo_ramp_ctrl.sv | 108 ++++++++++
 tb/tb_servo_ramp_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and FSM state type for frame-synchronous servo blocks
package servo_pkg;
  localparam int SERVO_PERIOD = 240000;
  localparam int SERVO_VAL_W = 8;
  localparam logic [SERVO_VAL_W-1:0] SERVO_CENTER = 8'd127;
  typedef enum logic {IDLE, UPDATE} state_t;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: free-running 0..PERIOD-1 counter with a registered pulse while the count sits at PERIOD-1
module frame_timer import servo_pkg::*; #(
  parameter int PERIOD = SERVO_PERIOD
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PRE = CW'(PERIOD - 2);
  logic [CW-1:0] cnt;
  // tick is raised one cycle early so the flop output coincides with cnt == LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= cnt == PRE;
    end
  end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: per-frame slew-limited servo positions; SERVO_RAMP_LIMIT_EN clamps accepted targets to [POS_MIN, POS_MAX]
module servo_ramp_ctrl import servo_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int PERIOD = SERVO_PERIOD,
  parameter int STEP = 4,
  parameter int POS_MIN = 0,
  parameter int POS_MAX = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_chan,
  input  logic [SERVO_VAL_W-1:0]        cmd_target,
  output logic                          cmd_err,
  output logic [SERVO_VAL_W*NUM_CH-1:0] pos,
  output logic                          frame_tick,
  output logic                          busy,
  output logic                          at_target
);
  localparam int VW = SERVO_VAL_W;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);
  localparam logic [VW-1:0] STEP_V = VW'(STEP);
  localparam logic [VW-1:0] LO = VW'(POS_MIN);
  localparam logic [VW-1:0] HI = VW'(POS_MAX);
`ifdef SERVO_RAMP_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  logic [VW-1:0] tgt [NUM_CH];
  logic [VW-1:0] cur [NUM_CH];
  state_t state, state_nx;
  logic [CHW-1:0] ch, ch_nx;
  logic last, accept, chan_ok, all_eq;
  logic [VW-1:0] tgt_in, sel_p, sel_t, step_nx;
  logic [VW:0] diff, mag;

  frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick)
  );

  assign cmd_ready = (state == IDLE) && !frame_tick;
  assign accept = cmd_valid && cmd_ready;
  assign chan_ok = {1'b0, cmd_chan} < 5'(NUM_CH);
  assign tgt_in = !LIMIT ? cmd_target : (cmd_target < LO) ? LO : (cmd_target > HI) ? HI : cmd_target;
  assign last = ch == CH_LAST;

  // sweep sequencing: a tick starts a one-channel-per-cycle walk, ch parks at 0 when idle
  always_comb begin
    state_nx = (state == IDLE) ? (frame_tick ? UPDATE : IDLE) : (last ? IDLE : UPDATE);
    ch_nx = (state == UPDATE && !last) ? ch + CHW'(1) : '0;
  end

  // shared step datapath: the sign bit of the 9-bit difference picks direction
  always_comb begin
    sel_p = cur[ch];
    sel_t = tgt[ch];
    diff = {1'b0, sel_t} - {1'b0, sel_p};
    mag = diff[VW] ? ~diff + (VW+1)'(1) : diff;
    step_nx = (mag <= {1'b0, STEP_V}) ? sel_t : diff[VW] ? sel_p - STEP_V : sel_p + STEP_V;
  end

  // every channel must sit on its target for at_target to assert
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < NUM_CH; i++) all_eq = all_eq & (cur[i] == tgt[i]);
  end

  // flatten the position array onto the output bus
  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_CH; i++) pos[i*VW +: VW] = cur[i];
  end

  // FSM state, sweep index and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      ch <= ch_nx;
      busy <= state_nx == UPDATE;
    end
  end

  // target/position storage, error pulse and registered at_target
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= SERVO_CENTER;
        cur[i] <= SERVO_CENTER;
      end
      cmd_err <= 1'b0;
      at_target <= 1'b1;
    end else begin
      if (state == UPDATE) cur[ch] <= step_nx;
      if (accept && chan_ok) tgt[cmd_chan[CHW-1:0]] <= tgt_in;
      cmd_err <= accept && !chan_ok;
      at_target <= all_eq;
    end
  end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: directed table, corner sequences and random commands against a timeline model
module tb_servo_ramp_ctrl;
  localparam int NUM_CH = 2;
  localparam int PERIOD = 100;
  localparam int STEP = 10;
  localparam int POS_MIN = 0;
  localparam int POS_MAX = 180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_chan = '0;
  logic [7:0] cmd_target = '0;
  logic cmd_err;
  logic [8*NUM_CH-1:0] pos;
  logic frame_tick;
  logic busy;
  logic at_target;

  int n_chk = 0;
  int n_fail = 0;
  bit check_en = 0;

  int t;
  int m_pos [NUM_CH];
  int m_tgt [NUM_CH];
  bit m_at, m_err;

  servo_ramp_ctrl #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .STEP(STEP), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_target (cmd_target),
    .cmd_err    (cmd_err),
    .pos        (pos),
    .frame_tick (frame_tick),
    .busy       (busy),
    .at_target  (at_target)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int clampv(int v);
`ifdef SERVO_RAMP_LIMIT_EN
    return v < POS_MIN ? POS_MIN : v > POS_MAX ? POS_MAX : v;
`else
    return v;
`endif
  endfunction

  function automatic int exp_bus();
    int v = 0;
    for (int i = 0; i < NUM_CH; i++) v |= m_pos[i] << (8*i);
    return v;
  endfunction

  // timeline model: t counts cycles since reset release; frame k's tick is at t = k*PERIOD-1,
  // its sweep visits channel j at t = k*PERIOD + j
  always @(posedge clk) begin : mdl
    int ph, d;
    bit tk, sw, eq;
    if (rst) begin
      t = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_pos[i] = 127; m_tgt[i] = 127; end
      m_at = 1;
      m_err = 0;
    end else begin
      ph = t % PERIOD;
      tk = ph == PERIOD - 1;
      sw = t >= PERIOD && ph < NUM_CH;
      eq = 1;
      for (int i = 0; i < NUM_CH; i++) eq &= m_pos[i] == m_tgt[i];
      m_at = eq;
      m_err = 0;
      if (sw) begin
        d = m_tgt[ph] - m_pos[ph];
        m_pos[ph] = d > STEP ? m_pos[ph] + STEP : d < -STEP ? m_pos[ph] - STEP : m_tgt[ph];
      end
      if (cmd_valid && !tk && !sw) begin
        if (cmd_chan < NUM_CH) m_tgt[cmd_chan] = clampv(cmd_target);
        else m_err = 1;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("pos", int'(pos), exp_bus());
      chk("frame_tick", int'(frame_tick), int'(t % PERIOD == PERIOD - 1));
      chk("busy", int'(busy), int'(t >= PERIOD && t % PERIOD < NUM_CH));
      chk("cmd_ready", int'(cmd_ready), int'(!(t % PERIOD == PERIOD - 1) && !(t >= PERIOD && t % PERIOD < NUM_CH)));
      chk("at_target", int'(at_target), int'(m_at));
      chk("cmd_err", int'(cmd_err), int'(m_err));
    end
  end

  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < 2*PERIOD) begin @(negedge clk); n++; end
    if (!frame_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_sweeps(int k);
    for (int i = 0; i < k; i++) begin wait_tick(); @(negedge clk); end
    repeat (NUM_CH + 1) @(negedge clk);
  endtask

  task automatic issue(int c, int v);
    int n = 0;
    while (!cmd_ready && n < 2*PERIOD) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1; cmd_chan = 4'(c); cmd_target = 8'(v);
    @(negedge clk);
    cmd_valid = 0;
    chk("cmd_err_pulse", int'(cmd_err), int'(c >= NUM_CH));
  endtask

  typedef struct {bit v; int ch; int tg; int sw; int p0; int p1; bit at;} vec_t;
  vec_t tbl [$];

  initial begin
    int n;
`ifdef SERVO_RAMP_LIMIT_EN
    tbl.push_back('{1, 0, 255, 5, 177, 127, 0});
    tbl.push_back('{0, 0, 0, 1, 180, 127, 1});
    tbl.push_back('{1, 1, 120, 1, 180, 120, 1});
    tbl.push_back('{1, 5, 9, 1, 180, 120, 1});
`else
    tbl.push_back('{1, 0, 200, 1, 137, 127, 0});
    tbl.push_back('{0, 0, 0, 6, 197, 127, 0});
    tbl.push_back('{0, 0, 0, 1, 200, 127, 1});
    tbl.push_back('{1, 1, 120, 1, 200, 120, 1});
    tbl.push_back('{1, 5, 9, 1, 200, 120, 1});
    tbl.push_back('{1, 1, 0, 2, 200, 100, 0});
    tbl.push_back('{1, 1, 105, 1, 200, 105, 1});
    tbl.push_back('{1, 0, 0, 3, 170, 105, 0});
`endif
    repeat (3) @(negedge clk);
    rst = 0;
    check_en = 1;
    chk("reset_pos", int'(pos), 16'h7F7F);
    chk("reset_at", int'(at_target), 1);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    n = 0;
    while (!frame_tick && n < 2*PERIOD) begin @(negedge clk); n++; end
    chk("first_tick_cycle", n, PERIOD - 1);

    foreach (tbl[i]) begin
      if (tbl[i].v) issue(tbl[i].ch, tbl[i].tg);
      wait_sweeps(tbl[i].sw);
      chk($sformatf("vec%0d_pos0", i), int'(pos[7:0]), tbl[i].p0);
      chk($sformatf("vec%0d_pos1", i), int'(pos[15:8]), tbl[i].p1);
      chk($sformatf("vec%0d_at", i), int'(at_target), int'(tbl[i].at));
    end

    wait_tick();
    cmd_valid = 1; cmd_chan = 4'd1; cmd_target = 8'd50;
    n = 0;
    while (!cmd_ready && n < 10) begin n++; @(negedge clk); end
    chk("holdoff_cycles", n, 1 + NUM_CH);
    @(negedge clk);
    cmd_valid = 0;
    wait_sweeps(1);
    chk("holdoff_pos1", int'(pos[15:8]), m_pos[1]);
    chk("holdoff_tgt_moved", int'(m_tgt[1]), 50);

    n = 0;
    while (!busy && n < 2*PERIOD) begin @(negedge clk); n++; end
    chk("busy_seen", int'(busy), 1);
    rst = 1;
    @(negedge clk);
    chk("midsweep_rst_pos", int'(pos), 16'h7F7F);
    chk("midsweep_rst_busy", int'(busy), 0);
    chk("midsweep_rst_at", int'(at_target), 1);
    chk("midsweep_rst_ready", int'(cmd_ready), 1);
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_chan = 4'($urandom_range(0, NUM_CH));
      cmd_target = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    cmd_valid = 0;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
